// File: rtl/logic_pkg.sv
// Shared definitions for the logic issue unit: ALUop encodings for the logic
// unit, MIPS opcode/funct codes for the supported logic instructions, and the
// issue FSM state type.
package logic_pkg;

    localparam logic [3:0] ALUOP_NONE = 4'b0000;
    localparam logic [3:0] ALUOP_AND  = 4'b0100;
    localparam logic [3:0] ALUOP_OR   = 4'b0101;
    localparam logic [3:0] ALUOP_XOR  = 4'b0110;
    localparam logic [3:0] ALUOP_NOR  = 4'b0111;

    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;

    localparam logic [5:0] OPC_RTYPE  = 6'h00;
    localparam logic [5:0] OPC_ANDI   = 6'h0C;
    localparam logic [5:0] OPC_ORI    = 6'h0D;
    localparam logic [5:0] OPC_XORI   = 6'h0E;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_op_decode.sv
// Combinational decoder for logic instructions.
// Maps a MIPS instruction word to the logic-unit ALUop, an operand-b select
// (register rt or zero-extended immediate), the destination register index
// and an illegal flag.
// Ports:
//   instr    in   32  instruction word
//   op       out  4   ALUop (0000 when illegal)
//   use_imm  out  1   operand b is the zero-extended immediate
//   rd       out  5   destination register index
//   illegal  out  1   not a supported logic instruction
// Build option: LOGIC_ISSUE_IMM_EN enables andi/ori/xori decode.
module logic_op_decode
    import logic_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  op,
    output logic        use_imm,
    output logic [4:0]  rd,
    output logic        illegal
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // rs index and shamt are not needed here; operands arrive as values.
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    always_comb begin
        op      = ALUOP_NONE;
        use_imm = 1'b0;
        illegal = 1'b1;
        // Non-R-type encodings carry the destination in the rt field,
        // including immediate forms that are rejected.
        rd      = instr[20:16];

        if (opcode == OPC_RTYPE) begin
            rd = instr[15:11];
            case (funct)
                FUNCT_AND: begin op = ALUOP_AND; illegal = 1'b0; end
                FUNCT_OR:  begin op = ALUOP_OR;  illegal = 1'b0; end
                FUNCT_XOR: begin op = ALUOP_XOR; illegal = 1'b0; end
                FUNCT_NOR: begin op = ALUOP_NOR; illegal = 1'b0; end
                default:   begin op = ALUOP_NONE; illegal = 1'b1; end
            endcase
        end
`ifdef LOGIC_ISSUE_IMM_EN
        else begin
            case (opcode)
                OPC_ANDI: begin op = ALUOP_AND; use_imm = 1'b1; illegal = 1'b0; end
                OPC_ORI:  begin op = ALUOP_OR;  use_imm = 1'b1; illegal = 1'b0; end
                OPC_XORI: begin op = ALUOP_XOR; use_imm = 1'b1; illegal = 1'b0; end
                default:  begin op = ALUOP_NONE; use_imm = 1'b0; illegal = 1'b1; end
            endcase
        end
`else
        else begin
            op      = ALUOP_NONE;
            use_imm = 1'b0;
            illegal = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/logic_issue_unit.sv
// Sequential issue front-end for the logic part of the ALU.
// Accepts an instruction with its two register operands, decodes the logic
// ALUop, presents registered a/b/ALUop to the logic unit for one EXEC cycle,
// captures the result and returns it with the destination index.
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   in_valid/in_ready   request handshake
//   in_instr            instruction word
//   in_rs_val/in_rt_val register operand values
//   lu_a/lu_b/lu_op     operands and ALUop to the logic unit
//   lu_result           combinational result from the logic unit
//   out_valid/out_ready response handshake
//   out_result          captured result (0 when illegal)
//   out_rd              destination register index
//   out_illegal         instruction not a supported logic op
// Build option: LOGIC_ISSUE_IMM_EN enables andi/ori/xori (in logic_op_decode).
//
// state | meaning
// IDLE  | ready for a request
// EXEC  | registered operands on lu_*, result captured at end of cycle
// RESP  | response held until out_ready; may accept next request same edge
module logic_issue_unit
    import logic_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    output logic [DATA_W-1:0] lu_a,
    output logic [DATA_W-1:0] lu_b,
    output logic [3:0]        lu_op,
    input  logic [DATA_W-1:0] lu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [4:0]        out_rd,
    output logic              out_illegal
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic [3:0]        op_q;
    logic [4:0]        rd_q;
    logic              ill_q;

    logic [3:0]        dec_op;
    logic              dec_use_imm;
    logic [4:0]        dec_rd;
    logic              dec_illegal;
    logic [DATA_W-1:0] imm_ext;

    logic              ready_c;
    logic              load_req;
    logic              cap_res;

    logic_op_decode u_decode (
        .instr   (in_instr),
        .op      (dec_op),
        .use_imm (dec_use_imm),
        .rd      (dec_rd),
        .illegal (dec_illegal)
    );

    assign imm_ext = {{(DATA_W-16){1'b0}}, in_instr[15:0]};

    always_comb begin
        state_d   = state_q;
        ready_c   = 1'b0;
        out_valid = 1'b0;
        load_req  = 1'b0;
        cap_res   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (in_valid) begin
                    load_req = 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                cap_res = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                out_valid = 1'b1;
                // Ready follows out_ready so a new request can overlap the
                // response transfer without a bubble.
                ready_c   = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load_req = 1'b1;
                        state_d  = ST_EXEC;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Held low while reset is asserted so no request is taken in reset.
    assign in_ready = ready_c & reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= ALUOP_NONE;
            rd_q    <= '0;
            ill_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_req) begin
                a_q   <= in_rs_val;
                b_q   <= dec_use_imm ? imm_ext : in_rt_val;
                op_q  <= dec_op;
                rd_q  <= dec_rd;
                ill_q <= dec_illegal;
            end
            if (cap_res) begin
                res_q <= ill_q ? '0 : lu_result;
            end
        end
    end

    assign lu_a        = a_q;
    assign lu_b        = b_q;
    assign lu_op       = op_q;
    assign out_result  = res_q;
    assign out_rd      = rd_q;
    assign out_illegal = ill_q;

endmodule

// File: tb/tb_logic_issue_unit.sv
module tb_logic_issue_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic [31:0] lu_a;
    logic [31:0] lu_b;
    logic [3:0]  lu_op;
    logic [31:0] lu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    logic_issue_unit #(.DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs_val   (in_rs_val),
        .in_rt_val   (in_rt_val),
        .lu_a        (lu_a),
        .lu_b        (lu_b),
        .lu_op       (lu_op),
        .lu_result   (lu_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Logic unit stand-in; op 0000 returns a sum so that an ungated
    // result on an illegal instruction is visible.
    always_comb begin
        case (lu_op)
            4'b0100: lu_result = lu_a & lu_b;
            4'b0101: lu_result = lu_a | lu_b;
            4'b0110: lu_result = lu_a ^ lu_b;
            4'b0111: lu_result = ~(lu_a | lu_b);
            default: lu_result = lu_a + lu_b;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rinstr(input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, 5'd1, 5'd2, rd, 5'd0, funct};
    endfunction

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_rs_val = '0; in_rt_val = '0;
        tick(); tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++;
        if ({out_result, out_rd, out_illegal, lu_a, lu_b, lu_op} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got res=%h rd=%0d ill=%0b a=%h b=%h op=%b want all 0",
                     out_result, out_rd, out_illegal, lu_a, lu_b, lu_op);
        end
        reset = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%0b want=1", in_ready); end
        tick();
    endtask

    task automatic test_rtype_and();
        in_instr = rinstr(5'd5, 6'h24); in_rs_val = 32'h0000_FFFF; in_rt_val = 32'h00FF_00FF;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL and_idle_ready got=%0b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (lu_op !== 4'b0100) begin bad++; $display("FAIL and_lu_op got=%b want=0100", lu_op); end
        total++; if (lu_a !== 32'h0000_FFFF || lu_b !== 32'h00FF_00FF) begin bad++; $display("FAIL and_lu_ab got=%h/%h want=0000ffff/00ff00ff", lu_a, lu_b); end
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL and_exec_hs got valid=%0b ready=%0b want 0/0", out_valid, in_ready); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL and_out_valid got=%0b want=1", out_valid); end
        total++; if (out_result !== 32'h0000_00FF) begin bad++; $display("FAIL and_result got=%h want=000000ff", out_result); end
        total++; if (out_rd !== 5'd5 || out_illegal !== 1'b0) begin bad++; $display("FAIL and_rd_ill got rd=%0d ill=%0b want 5/0", out_rd, out_illegal); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL and_drain got=%0b want=0", out_valid); end
    endtask

    task automatic test_rtype_ops();
        logic [5:0]  functs [3] = '{6'h25, 6'h26, 6'h27};
        logic [3:0]  ops    [3] = '{4'b0101, 4'b0110, 4'b0111};
        logic [31:0] ress   [3] = '{32'h0000_07FF, 32'h0000_07E0, 32'hFFFF_F800};
        for (int i = 0; i < 3; i++) begin
            in_instr = rinstr(5'(10 + i), functs[i]);
            in_rs_val = 32'h0000_001F; in_rt_val = 32'h0000_07FF;
            in_valid = 1'b1; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            total++; if (lu_op !== ops[i]) begin bad++; $display("FAIL op%0d_lu_op got=%b want=%b", i, lu_op, ops[i]); end
            tick();
            total++; if (out_valid !== 1'b1 || out_result !== ress[i]) begin bad++; $display("FAIL op%0d_result got v=%0b res=%h want 1/%h", i, out_valid, out_result, ress[i]); end
            total++; if (out_rd !== 5'(10 + i) || out_illegal !== 1'b0) begin bad++; $display("FAIL op%0d_rd got rd=%0d ill=%0b want %0d/0", i, out_rd, out_illegal, 10 + i); end
            tick();
        end
    endtask

    task automatic test_illegal();
        in_instr = rinstr(5'd7, 6'h20); in_rs_val = 32'h0000_001F; in_rt_val = 32'h0000_07FF;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (lu_op !== 4'b0000) begin bad++; $display("FAIL ill_lu_op got=%b want=0000", lu_op); end
        tick();
        total++; if (out_valid !== 1'b1 || out_illegal !== 1'b1) begin bad++; $display("FAIL ill_flag got v=%0b ill=%0b want 1/1", out_valid, out_illegal); end
        total++; if (out_result !== 32'h0 || out_rd !== 5'd7) begin bad++; $display("FAIL ill_result got res=%h rd=%0d want 0/7", out_result, out_rd); end
        tick();
    endtask

    task automatic test_ori();
        in_instr = {6'h0D, 5'd1, 5'd9, 16'hABCD};
        in_rs_val = 32'h1234_0000; in_rt_val = 32'hDEAD_BEEF;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef LOGIC_ISSUE_IMM_EN
        total++; if (lu_op !== 4'b0101 || lu_b !== 32'h0000_ABCD) begin bad++; $display("FAIL ori_exec got op=%b b=%h want 0101/0000abcd", lu_op, lu_b); end
        tick();
        total++; if (out_result !== 32'h1234_ABCD || out_illegal !== 1'b0) begin bad++; $display("FAIL ori_result got res=%h ill=%0b want 1234abcd/0", out_result, out_illegal); end
`else
        total++; if (lu_op !== 4'b0000) begin bad++; $display("FAIL ori_exec got op=%b want 0000", lu_op); end
        tick();
        total++; if (out_result !== 32'h0 || out_illegal !== 1'b1) begin bad++; $display("FAIL ori_illegal got res=%h ill=%0b want 0/1", out_result, out_illegal); end
`endif
        total++; if (out_valid !== 1'b1 || out_rd !== 5'd9) begin bad++; $display("FAIL ori_rd got v=%0b rd=%0d want 1/9", out_valid, out_rd); end
        tick();
    endtask

    task automatic test_back_to_back();
        in_instr = rinstr(5'd5, 6'h24); in_rs_val = 32'h0000_FFFF; in_rt_val = 32'h00FF_00FF;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        // A pending request must not be taken while the response stalls.
        in_instr = rinstr(5'd6, 6'h26); in_rs_val = 32'h0000_001F; in_rt_val = 32'h0000_07FF;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (out_valid !== 1'b1 || out_result !== 32'h0000_00FF || out_rd !== 5'd5 ||
                in_ready !== 1'b0 || lu_op !== 4'b0100) begin
                bad++;
                $display("FAIL stall%0d got v=%0b res=%h rd=%0d rdy=%0b op=%b want 1/000000ff/5/0/0100",
                         i, out_valid, out_result, out_rd, in_ready, lu_op);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || lu_op !== 4'b0110 || lu_a !== 32'h0000_001F) begin bad++; $display("FAIL b2b_exec got v=%0b op=%b a=%h want 0/0110/0000001f", out_valid, lu_op, lu_a); end
        tick();
        total++; if (out_valid !== 1'b1 || out_result !== 32'h0000_07E0 || out_rd !== 5'd6) begin bad++; $display("FAIL b2b_resp got v=%0b res=%h rd=%0d want 1/000007e0/6", out_valid, out_result, out_rd); end
        tick();
    endtask

    task automatic test_reset_in_resp();
        in_instr = rinstr(5'd3, 6'h25); in_rs_val = 32'h0000_001F; in_rt_val = 32'h0000_07FF;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%0b want=1", out_valid); end
        reset = 1'b0;
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b want=0", in_ready); end
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            {out_result, out_rd, out_illegal, lu_a, lu_b, lu_op} !== '0) begin
            bad++;
            $display("FAIL rst_after got v=%0b rdy=%0b res=%h rd=%0d ill=%0b a=%h b=%h op=%b want 0/1/all 0",
                     out_valid, in_ready, out_result, out_rd, out_illegal, lu_a, lu_b, lu_op);
        end
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_no_resp got=%0b want=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_rtype_and();
        test_rtype_ops();
        test_illegal();
        test_ori();
        test_back_to_back();
        test_reset_in_resp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_issue_unit.md
# logic_issue_unit

Sequential front-end for the logic part of the ALU in the single-cycle processor. Accepts one instruction plus two register operands over a valid/ready handshake and decodes the logic opcodes to the 4-bit `ALUop`. Drives registered `a`, `b` and `ALUop` into the logic unit, captures its result and returns it with the destination register index over a second valid/ready handshake. It is the initiator side of the logic unit's `a`/`b`/`ALUop`/`result` interface.

## Interface
- `DATA_W`, 32, operand/result width
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  unit can accept request
- `in_instr`  in  32  MIPS-format instruction word
- `in_rs_val`  in  DATA_W  value of rs
- `in_rt_val`  in  DATA_W  value of rt
- `lu_a`  out  DATA_W  operand a to logic unit
- `lu_b`  out  DATA_W  operand b to logic unit
- `lu_op`  out  4  ALUop to logic unit
- `lu_result`  in  DATA_W  combinational result from logic unit
- `out_valid`  out  1  response valid
- `out_ready`  in  1  consumer accepts response
- `out_result`  out  DATA_W  captured result (0 when illegal)
- `out_rd`  out  5  destination register index
- `out_illegal`  out  1  instruction not a supported logic op

## Operation
- Decode, R-type (opcode 0): funct 0x24 gives 4'b0100 (AND), 0x25 gives 4'b0101 (OR), 0x26 gives 4'b0110 (XOR), 0x27 gives 4'b0111 (NOR).
- R-type operands: a=rs, b=rt. Destination is `instr[15:11]`.
- I-type decode (macro-gated): opcode 0x0C gives 4'b0100, 0x0D gives 4'b0101, 0x0E gives 4'b0110.
- I-type operands: a=rs, b=zero-extended `instr[15:0]`. Destination is `instr[20:16]`.
- Any other encoding is illegal:
  - `lu_op` is driven 4'b0000 for the EXEC cycle.
  - `out_result` is 0 and `out_illegal` is 1.
  - The response is still returned.
- FSM states IDLE, EXEC, RESP.
  - IDLE: `in_ready`=1. On `in_valid`, register operands, op, rd and illegal flag, then go to EXEC.
  - EXEC: `lu_a`/`lu_b`/`lu_op` hold the registered values. Capture `lu_result` (or 0 if illegal) into the output register, then go to RESP.
  - RESP: `out_valid`=1 and outputs stay stable until `out_ready`.
    - `out_ready` with `in_valid` (and `in_ready`=`out_ready`): accept the new request in the same cycle and go to EXEC.
    - `out_ready` without `in_valid`: go to IDLE.
    - No `out_ready`: stay in RESP.
- `lu_*` outputs hold their last values outside EXEC. No X is ever driven after reset.

## Timing
- Reset (`reset`=0 at an edge) returns the FSM to IDLE and clears all outputs:
  - `in_ready`=0 during reset, 1 on the first cycle after reset.
  - `out_valid`=0, `out_result`=0, `out_rd`=0, `out_illegal`=0.
  - `lu_a`=0, `lu_b`=0, `lu_op`=0.
- Reset mid-operation (EXEC or RESP) drops the in-flight response with no handshake.
- Latency: request accepted at edge N, `lu_*` valid after N, `out_valid` high after edge N+1.
- Throughput: one request every 2 cycles with `out_ready` tied high.
- Handshake: a transfer occurs only on an edge where valid and ready are both high. A request held with `in_ready`=0 is not consumed.
- Simultaneous response accept and new request in RESP: both transfers complete on the same edge, with no bubble beyond EXEC.

## Configuration
- `LOGIC_ISSUE_IMM_EN` defined: I-type opcodes 0x0C/0x0D/0x0E decode as described under Operation.
- `LOGIC_ISSUE_IMM_EN` undefined: those opcodes are illegal (`out_illegal`=1, `out_result`=0, `out_rd`=`instr[20:16]`).

## Structure
- Shared package `logic_pkg`:
  - ALUop constants for AND/OR/XOR/NOR.
  - Funct codes 0x24–0x27 and opcodes 0x00/0x0C/0x0D/0x0E.
  - FSM state enum.
- One sub-module: `logic_op_decode`, purely combinational. Maps the instruction to op, operand select, rd and illegal. Holds the macro-gated I-type decode.
- `logic_issue_unit` holds the FSM and registers, and instantiates the existing logic part for standalone benching only via the bench.

## Test plan
- R-type AND: funct 0x24, rs=0x0000_FFFF, rt=0x00FF_00FF → `lu_op`=4'b0100 in EXEC. Response `out_result`=0x0000_00FF, `out_rd`=`instr[15:11]`, 2 cycles after accept.
- Each of OR/XOR/NOR with rs=0x0000_001F, rt=0x0000_07FF → results 0x7FF, 0x7E0, 0xFFFF_F800.
- Backpressure: hold `out_ready`=0 for 5 cycles → `out_valid` stays 1, outputs stable, `in_ready`=0. Then raise `out_ready` together with `in_valid` → both transfers occur on the same edge.
- Illegal: funct 0x20 → `out_illegal`=1, `out_result`=0, `lu_op`=0 in EXEC.
- `ori` opcode 0x0D, rs=0x1234_0000, imm=0xABCD:
  - Macro defined: result 0x1234_ABCD, `out_rd`=`instr[20:16]`.
  - Macro undefined: `out_illegal`=1.
- Reset asserted during RESP → the next cycle after release shows `out_valid`=0, all outputs 0, `in_ready`=1.
